// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and default constants for the push-button front end that feeds
// the 3-bit T-flip-flop counter.
//   db_state_t          : debounce / auto-repeat FSM state encoding
//   DB_SYNC_STAGES      : default synchroniser depth
//   DB_DEBOUNCE_CYCLES  : default stable-sample count to accept press/release
//   DB_REPEAT_DELAY     : default cycles from first step to first repeat step
//   DB_REPEAT_PERIOD    : default cycles between repeat steps
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_REPEAT,
        ST_RELEASE_WAIT
    } db_state_t;

    localparam int unsigned DB_SYNC_STAGES     = 2;
    localparam int unsigned DB_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DB_REPEAT_DELAY    = 16;
    localparam int unsigned DB_REPEAT_PERIOD   = 4;

endpackage : debounce_pkg

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// N-flop synchroniser for a single asynchronous input bit.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset (all flops cleared)
//   d_i    : asynchronous input
//   q_o    : synchronised output, STAGES clock edges behind d_i
// STAGES must be 2 or more.
// -----------------------------------------------------------------------------
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/debounce_step_gen.sv
// -----------------------------------------------------------------------------
// debounce_step_gen
// Turns a raw, bouncing push-button into clean single-cycle step pulses for the
// stage-0 toggle enable of the 3-bit T-flip-flop counter, with optional
// auto-repeat while the button is held.
//   clk           : rising-edge clock
//   reset         : asynchronous, active-low reset
//   btn_raw       : raw asynchronous button level (may bounce)
//   en            : synchronous enable; gates step and freezes repeat counting,
//                   level tracking continues regardless
//   step          : registered single-cycle toggle request
//   btn_level     : registered debounced button level
//   repeat_active : high while the FSM is in REPEAT
// -----------------------------------------------------------------------------
module debounce_step_gen
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DB_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DB_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DB_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DB_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic en,
    output logic step,
    output logic btn_level,
    output logic repeat_active
);

    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RD_C   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP_C   = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic REPEAT_EN          = (REPEAT_DELAY != 0);
    // With a single-sample debounce the first differing sample already
    // completes the press/release, so the wait states are skipped.
    localparam logic FIRST_SAMPLE_DONE  = (DEBOUNCE_CYCLES <= 1);

    logic             btn_s;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             step_q;
    logic             level_q;
    logic             rep_q;
    logic             deb_done;
    logic             hold_due;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_raw),
        .q_o   (btn_s)
    );

    // Saturating increment and the two threshold tests derived from it.
    // hold_due compares against the delay in HELD and the period in REPEAT.
    always_comb begin
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;
        deb_done = (cnt_inc >= DEB_C);
        hold_due = (cnt_inc == ((state_q == ST_REPEAT) ? RP_C : RD_C));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            level_q <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (btn_s) begin
                        if (FIRST_SAMPLE_DONE) begin
                            state_q <= ST_HELD;
                            level_q <= 1'b1;
                            step_q  <= en;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_PRESS_WAIT;
                            cnt_q   <= ONE_C;
                        end
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (deb_done) begin
                        state_q <= ST_HELD;
                        level_q <= 1'b1;
                        step_q  <= en;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                ST_HELD: begin
                    // A low sample is checked first so a release always beats
                    // a step falling due on the same edge.
                    if (!btn_s) begin
                        if (FIRST_SAMPLE_DONE) begin
                            state_q <= ST_IDLE;
                            level_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_RELEASE_WAIT;
                            cnt_q   <= ONE_C;
                        end
                    end else if (en && REPEAT_EN) begin
                        if (hold_due) begin
                            state_q <= ST_REPEAT;
                            rep_q   <= 1'b1;
                            step_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end

                ST_REPEAT: begin
                    if (!btn_s) begin
                        rep_q <= 1'b0;
                        if (FIRST_SAMPLE_DONE) begin
                            state_q <= ST_IDLE;
                            level_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_RELEASE_WAIT;
                            cnt_q   <= ONE_C;
                        end
                    end else if (en) begin
                        if (hold_due) begin
                            step_q <= 1'b1;
                            cnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end

                ST_RELEASE_WAIT: begin
                    // A high sample before the release is confirmed goes back
                    // to HELD with a fresh delay and no step.
                    if (btn_s) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (deb_done) begin
                        state_q <= ST_IDLE;
                        level_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    rep_q   <= 1'b0;
                end
            endcase
        end
    end

    assign step          = step_q;
    assign btn_level     = level_q;
    assign repeat_active = rep_q;

endmodule : debounce_step_gen

// File: tb/tb_debounce_step_gen.sv
// -----------------------------------------------------------------------------
// tb_debounce_step_gen
// Self-checking bench for debounce_step_gen with default parameters. A
// behavioural model (delay queue + run-length / hold-time counting) predicts
// the outputs every cycle; directed scenarios also check event edges against
// fixed expected edge numbers. A 3-bit T-flop counter is driven by step.
// -----------------------------------------------------------------------------
module tb_debounce_step_gen;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 16;
    localparam int RP   = 4;

    logic clk;
    logic reset;
    logic btn_raw;
    logic en;
    logic step;
    logic btn_level;
    logic repeat_active;

    debounce_step_gen #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .en            (en),
        .step          (step),
        .btn_level     (btn_level),
        .repeat_active (repeat_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 3-bit ripple of T flip-flops; stage 0 toggles on step.
    logic [2:0] tq;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tq <= 3'b000;
        end else begin
            if (step)                   tq[0] <= ~tq[0];
            if (step && tq[0])          tq[1] <= ~tq[1];
            if (step && tq[0] && tq[1]) tq[2] <= ~tq[2];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit mq[$];        // raw samples in flight through the synchroniser
    bit m_level;      // debounced level
    bit m_step;
    bit m_rep;        // auto-repeat phase reached
    int m_run;        // consecutive samples disagreeing with m_level
    int m_hold;       // enabled held cycles since last step

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
        m_level = 0; m_step = 0; m_rep = 0; m_run = 0; m_hold = 0;
    endtask

    task automatic model_edge();
        bit s;
        if (!reset) begin
            model_reset();
            return;
        end
        s = mq[0];
        void'(mq.pop_front());
        mq.push_back(btn_raw);
        m_step = 0;
        if (!m_level) begin
            if (s) begin
                m_run++;
                if (m_run >= DEB) begin
                    m_level = 1; m_run = 0; m_hold = 0; m_rep = 0; m_step = en;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (!s) begin
                m_rep = 0; m_hold = 0; m_run++;
                if (m_run >= DEB) begin
                    m_level = 0; m_run = 0;
                end
            end else if (m_run > 0) begin
                m_run = 0; m_hold = 0; m_rep = 0;
            end else if (en && RD != 0) begin
                m_hold++;
                if (m_hold == (m_rep ? RP : RD)) begin
                    m_step = 1; m_rep = 1; m_hold = 0;
                end
            end
        end
    endtask

    // ---------------- per-cycle driver / recorder ----------------
    int edge_no;
    int step_edges[$];
    int step_total = 0;
    int rise_edge, fall_edge, rep_rise, rep_fall;
    bit prev_level = 0;
    bit prev_rep = 0;

    task automatic begin_scn();
        step_edges.delete();
        edge_no = 0;
        rise_edge = -1; fall_edge = -1; rep_rise = -1; rep_fall = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        edge_no++;
        #1;
        check("step", step, m_step);
        check("btn_level", btn_level, m_level);
        check("repeat_active", repeat_active, m_rep);
        if (step) begin
            step_edges.push_back(edge_no);
            step_total++;
        end
        if (btn_level && !prev_level) rise_edge = edge_no;
        if (!btn_level && prev_level) fall_edge = edge_no;
        if (repeat_active && !prev_rep) rep_rise = edge_no;
        if (!repeat_active && prev_rep) rep_fall = edge_no;
        prev_level = btn_level;
        prev_rep   = repeat_active;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    function automatic int step_at(input int idx);
        return (idx < step_edges.size()) ? step_edges[idx] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rep[6];
        int base_steps;
        exp_rep = '{6, 22, 26, 30, 34, 38};

        reset = 1'b0; btn_raw = 1'b0; en = 1'b1;
        model_reset();
        #12;
        check("reset_step", step, 0);
        check("reset_level", btn_level, 0);
        check("reset_repeat", repeat_active, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        run(4);

        // Clean press
        begin_scn();
        btn_raw = 1; run(10);
        btn_raw = 0; run(12);
        check("clean_nsteps", step_edges.size(), 1);
        check("clean_step_edge", step_at(0), 6);
        check("clean_rise", rise_edge, 6);
        check("clean_fall", fall_edge, 16);

        // Bounce: hi3 lo1 hi3 lo1 then steady high from edge 9
        begin_scn();
        btn_raw = 1; run(3);
        btn_raw = 0; run(1);
        btn_raw = 1; run(3);
        btn_raw = 0; run(1);
        btn_raw = 1; run(12);
        btn_raw = 0; run(10);
        check("bounce_nsteps", step_edges.size(), 1);
        check("bounce_step_edge", step_at(0), 14);

        // Auto-repeat; release seen at edge 42 pre-empts the due step
        begin_scn();
        btn_raw = 1; run(39);
        btn_raw = 0; run(10);
        check("repeat_nsteps", step_edges.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("repeat_step%0d", i), step_at(i), exp_rep[i]);
        check("repeat_rise", rep_rise, 22);
        check("repeat_fall", rep_fall, 42);

        // Enable gating
        begin_scn();
        en = 0; btn_raw = 1; run(30);
        en = 1; run(30);
        btn_raw = 0; run(10);
        check("gate_rise", rise_edge, 6);
        check("gate_first_step", step_at(0), 46);
        check("gate_nsteps", step_edges.size(), 5);

        // Reset mid-REPEAT
        begin_scn();
        btn_raw = 1; run(28);
        reset = 0;
        #1;
        check("midrst_step", step, 0);
        check("midrst_level", btn_level, 0);
        check("midrst_repeat", repeat_active, 0);
        model_reset();
        run(2);
        reset = 1;
        begin_scn();
        run(8);
        check("postrst_nsteps", step_edges.size(), 1);
        check("postrst_step_edge", step_at(0), 6);
        btn_raw = 0; run(10);

        // Randomised segments against the model
        for (int seg = 0; seg < 150; seg++) begin
            btn_raw = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) run($urandom_range(1, 3));
            else run($urandom_range(4, 30));
        end
        en = 1; btn_raw = 0; run(12);

        // Integration with the 3-bit counter
        reset = 0;
        #1;
        model_reset();
        run(1);
        reset = 1;
        begin_scn();
        base_steps = step_total;
        for (int p = 0; p < 9; p++) begin
            btn_raw = 1; run(10);
            btn_raw = 0; run(10);
        end
        check("integ_nsteps", step_total - base_steps, 9);
        check("integ_counter", tq, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_debounce_step_gen
